// File: rtl/fetch_prefetch_unit_if.sv
// Bus bundle between the fetch front end, the instruction memory and the IF/ID stage.
// master = fetch unit view, slave = memory/decode/branch-resolution view.
interface fetch_prefetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    modport master (
        output imem_req_valid, imem_req_addr, id_valid, id_pc, id_inst,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, id_valid, id_pc, id_inst,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, id_ready
    );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Sequential instruction prefetcher: credit-limited requests, in-order response buffer,
// redirect flush with exact accounting of stale in-flight responses.
module fetch_prefetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                   clk,
    input logic                   rst,
    fetch_prefetch_unit_if.master bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW:0]   CREDITS  = (CW+1)'(DEPTH);

    logic [31:0]   fetch_pc_r;
    logic [31:0]   exp_pc_r;
    logic [63:0]   fifo_r [DEPTH];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] outstanding_r;
    logic [CW-1:0] drop_cnt_r;

    logic [CW:0]   inflight_s;
    logic          credit_s;
    logic          req_fire_s;
    logic          rsp_ok_s;
    logic [CW-1:0] rsp_dec_s;
    logic [CW-1:0] req_inc_s;
    logic          push_s;
    logic          pop_s;
    logic          id_valid_s;
    logic [63:0]   head_s;

    // Credit check and handshake qualification; rst only gates the visible request
    always_comb begin
        inflight_s = {1'b0, count_r} + {1'b0, outstanding_r};
        credit_s   = (inflight_s < CREDITS);
        req_fire_s = credit_s & ~bus.redirect & bus.imem_req_ready;
        req_inc_s  = req_fire_s ? CNT_ONE : CNT_ZERO;
        rsp_ok_s   = bus.imem_rsp_valid & (outstanding_r != CNT_ZERO);
        rsp_dec_s  = rsp_ok_s ? CNT_ONE : CNT_ZERO;
        id_valid_s = (count_r != CNT_ZERO);
        push_s     = rsp_ok_s & (drop_cnt_r == CNT_ZERO) & ~bus.redirect;
        pop_s      = id_valid_s & bus.id_ready & ~bus.redirect;
        head_s     = fifo_r[rd_ptr_r];
    end

    assign bus.imem_req_valid = rst & ~bus.redirect & credit_s;
    assign bus.imem_req_addr  = fetch_pc_r;
    assign bus.id_valid       = id_valid_s;
    assign bus.id_pc          = id_valid_s ? head_s[63:32] : 32'h0000_0000;
    assign bus.id_inst        = id_valid_s ? head_s[31:0]  : 32'h0000_0000;

    // Buffer storage; contents are only observed through the valid-gated head
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_r[wr_ptr_r] <= {exp_pc_r, bus.imem_rsp_data};
        end
    end

    // PCs, pointers and credit/drop counters; redirect overrides any same-cycle push/pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_r    <= RESET_PC;
            exp_pc_r      <= RESET_PC;
            rd_ptr_r      <= {PW{1'b0}};
            wr_ptr_r      <= {PW{1'b0}};
            count_r       <= CNT_ZERO;
            outstanding_r <= CNT_ZERO;
            drop_cnt_r    <= CNT_ZERO;
        end else if (bus.redirect) begin
            fetch_pc_r    <= {bus.redirect_pc[31:2], 2'b00};
            exp_pc_r      <= {bus.redirect_pc[31:2], 2'b00};
            rd_ptr_r      <= {PW{1'b0}};
            wr_ptr_r      <= {PW{1'b0}};
            count_r       <= CNT_ZERO;
            // Every request still in flight after this cycle belongs to the old stream
            outstanding_r <= outstanding_r - rsp_dec_s;
            drop_cnt_r    <= outstanding_r - rsp_dec_s;
        end else begin
            if (req_fire_s) begin
                fetch_pc_r <= fetch_pc_r + 32'd4;
            end
            outstanding_r <= outstanding_r + req_inc_s - rsp_dec_s;
            if (rsp_ok_s && (drop_cnt_r != CNT_ZERO)) begin
                drop_cnt_r <= drop_cnt_r - CNT_ONE;
            end
            if (push_s) begin
                exp_pc_r <= exp_pc_r + 32'd4;
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + CNT_ONE;
            end else if (pop_s && !push_s) begin
                count_r <= count_r - CNT_ONE;
            end
        end
    end
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Scoreboard bench: a latency-configurable memory model feeds the prefetcher; every
// accepted request queues its expected {pc, inst}, compared when decode takes an entry.
module tb_fetch_prefetch_unit;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;

    fetch_prefetch_unit_if bus();

    fetch_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mem_q[$];
    logic [63:0] exp_q[$];
    int          n_tests  = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          mem_lat  = 1;
    int          req_cnt  = 0;
    bit          mem_hold = 1'b0;
    logic [31:0] model_pc = RESET_PC;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    // One clock cycle: sample before the edge, update models at the edge, drive memory at negedge
    task automatic tick();
        logic        s_req, s_rsp, s_id, s_redir;
        logic [31:0] s_addr, s_rpc, s_pc, s_inst;
        logic [63:0] e;
        #1;
        s_req   = bus.imem_req_valid & bus.imem_req_ready;
        s_addr  = bus.imem_req_addr;
        s_rsp   = bus.imem_rsp_valid;
        s_id    = bus.id_valid & bus.id_ready;
        s_pc    = bus.id_pc;
        s_inst  = bus.id_inst;
        s_redir = bus.redirect;
        s_rpc   = bus.redirect_pc;
        @(posedge clk);
        cyc++;
        if (rst) begin
            if (s_rsp && mem_q.size() > 0) void'(mem_q.pop_front());
            if (s_redir) begin
                exp_q.delete();
                model_pc = {s_rpc[31:2], 2'b00};
            end else begin
                if (s_id) begin
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL id_unexpected: got pc=%h inst=%h, expected no entry", s_pc, s_inst);
                    end else begin
                        e = exp_q.pop_front();
                        if ({s_pc, s_inst} !== e) begin
                            n_fail++;
                            $display("FAIL id_entry: got pc=%h inst=%h, expected pc=%h inst=%h",
                                     s_pc, s_inst, e[63:32], e[31:0]);
                        end
                    end
                end
                if (s_req) begin
                    n_tests++;
                    if (s_addr !== model_pc) begin
                        n_fail++;
                        $display("FAIL req_addr: got %h, expected %h", s_addr, model_pc);
                    end
                    mem_q.push_back('{addr: s_addr, due: cyc + mem_lat - 1});
                    exp_q.push_back({s_addr, inst_of(s_addr)});
                    model_pc = s_addr + 32'd4;
                    req_cnt++;
                end
            end
        end
        @(negedge clk);
        if (!mem_hold && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = inst_of(mem_q[0].addr);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'h0000_0000;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic apply_reset();
        rst                = 1'b0;
        mem_hold           = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.redirect       = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.id_ready       = 1'b1;
        mem_q.delete();
        exp_q.delete();
        model_pc = RESET_PC;
        repeat (2) @(negedge clk);
        rst      = 1'b1;
        mem_hold = 1'b0;
    endtask

    task automatic test_reset();
        rst                = 1'b1;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0000_0000;
        bus.redirect       = 1'b0;
        bus.redirect_pc    = 32'h0000_0000;
        bus.id_ready       = 1'b1;
        #1 rst = 1'b0;
        #1;
        check("rst_req_valid", {31'h0, bus.imem_req_valid}, 32'h0);
        check("rst_req_addr", bus.imem_req_addr, RESET_PC);
        check("rst_id_valid", {31'h0, bus.id_valid}, 32'h0);
        check("rst_id_pc", bus.id_pc, 32'h0);
        check("rst_id_inst", bus.id_inst, 32'h0);
    endtask

    task automatic test_stream();
        int hits = 0;
        apply_reset();
        mem_lat = 1;
        repeat (3) tick();
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.id_valid === 1'b1) hits++;
        end
        check("t1_throughput", hits, 32'd12);
    endtask

    task automatic test_backpressure();
        apply_reset();
        mem_lat      = 1;
        bus.id_ready = 1'b0;
        req_cnt      = 0;
        repeat (10) tick();
        check("t2_req_count", req_cnt, 32'd4);
        check("t2_req_valid_low", {31'h0, bus.imem_req_valid}, 32'h0);
        check("t2_head_pc", bus.id_pc, 32'h0);
        bus.id_ready = 1'b1;
        repeat (10) tick();
    endtask

    task automatic test_redirect_drop();
        int k = 0;
        apply_reset();
        mem_lat = 3;
        while (k < 20 && mem_q.size() != 3) begin tick(); k++; end
        check("t3_outstanding", mem_q.size(), 32'd3);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0103;
        #1;
        check("t3_no_req_in_redirect", {31'h0, bus.imem_req_valid}, 32'h0);
        tick();
        bus.redirect = 1'b0;
        k = 0;
        while (k < 30 && bus.id_valid !== 1'b1) begin tick(); k++; end
        check("t3_first_id_pc", bus.id_valid ? bus.id_pc : 32'hDEAD_BEEF, 32'h0000_0100);
        repeat (8) tick();
    endtask

    task automatic test_redirect_collide();
        int k = 0;
        apply_reset();
        mem_lat = 1;
        while (k < 10 && !(bus.id_valid && bus.imem_rsp_valid)) begin tick(); k++; end
        check("t4_setup", {31'h0, bus.id_valid & bus.imem_rsp_valid}, 32'h1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0200;
        tick();
        bus.redirect = 1'b0;
        check("t4_id_valid_cleared", {31'h0, bus.id_valid}, 32'h0);
        #1;
        check("t4_next_req_valid", {31'h0, bus.imem_req_valid}, 32'h1);
        check("t4_next_req_addr", bus.imem_req_addr, 32'h0000_0200);
        repeat (8) tick();
    endtask

    task automatic test_req_stall();
        int k = 0;
        int bad = 0;
        int n0;
        apply_reset();
        mem_lat = 1;
        while (k < 10 && model_pc != 32'h8) begin tick(); k++; end
        bus.imem_req_ready = 1'b0;
        n0 = req_cnt;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.imem_req_addr !== 32'h8 || bus.imem_req_valid !== 1'b1) bad++;
        end
        check("t5_addr_stable", bad, 32'd0);
        check("t5_no_handshake", req_cnt - n0, 32'd0);
        bus.imem_req_ready = 1'b1;
        repeat (6) tick();
    endtask

    task automatic test_async_reset();
        int k = 0;
        apply_reset();
        mem_lat      = 3;
        bus.id_ready = 1'b0;
        while (k < 20 && !(mem_q.size() == 2 && bus.id_valid === 1'b1)) begin tick(); k++; end
        check("t6_setup", mem_q.size(), 32'd2);
        #2;
        rst                = 1'b0;
        mem_hold           = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        exp_q.delete();
        model_pc = RESET_PC;
        #1;
        check("t6_async_id_valid", {31'h0, bus.id_valid}, 32'h0);
        check("t6_async_req_valid", {31'h0, bus.imem_req_valid}, 32'h0);
        repeat (2) @(negedge clk);
        rst                = 1'b1;
        bus.imem_req_ready = 1'b0;
        bus.id_ready       = 1'b1;
        mem_hold           = 1'b0;
        repeat (4) tick();
        check("t6_stale_consumed", mem_q.size(), 32'd0);
        check("t6_stale_not_shown", {31'h0, bus.id_valid}, 32'h0);
        bus.imem_req_ready = 1'b1;
        repeat (8) tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drop();
        test_redirect_collide();
        test_req_stall();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
